// File: rtl/bus_mem_ctrl_if.sv
// rtl/bus_mem_ctrl_if.sv - request/ready bus between a requester and bus_mem_ctrl
interface bus_mem_ctrl_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 8
) ();
    logic              req;
    logic              rw;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data_in;
    logic [DATA_W-1:0] data_out;
    logic              ready;
    logic              busy;
    logic              wp_fault;

    modport master (
        output req, rw, addr, data_in,
        input  data_out, ready, busy, wp_fault
    );

    modport slave (
        input  req, rw, addr, data_in,
        output data_out, ready, busy, wp_fault
    );
endinterface

// File: rtl/bus_mem_ctrl.sv
// rtl/bus_mem_ctrl.sv - mirrored synchronous memory with wait states and write-protect window
module bus_mem_ctrl #(
    parameter int ADDR_W      = 16,
    parameter int DATA_W      = 8,
    parameter int DEPTH_LOG2  = 11,
    parameter int WAIT_STATES = 0,
    parameter int WP_EN       = 0,
    parameter int WP_BASE     = 0,
    parameter int WP_LIMIT    = 0
) (
    input  logic          clock,
    input  logic          reset,
    bus_mem_ctrl_if.slave bus
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2-1:0] WP_LO   = DEPTH_LOG2'(WP_BASE);
    localparam logic [DEPTH_LOG2-1:0] WP_SPAN = DEPTH_LOG2'(WP_LIMIT - WP_BASE);

    generate
        if (WAIT_STATES < 0 || WAIT_STATES > 15) begin : g_bad_wait
            $error("bus_mem_ctrl: WAIT_STATES must be in 0..15");
        end
        if (ADDR_W < DEPTH_LOG2) begin : g_bad_addr
            $error("bus_mem_ctrl: ADDR_W must be >= DEPTH_LOG2");
        end
        if (WP_BASE > WP_LIMIT) begin : g_bad_wp
            $error("bus_mem_ctrl: WP_BASE must be <= WP_LIMIT");
        end
        // Address bits above the physical index are deliberately dropped (mirroring).
        if (ADDR_W > DEPTH_LOG2) begin : g_mirror
            logic unused_upper_addr;
            assign unused_upper_addr = ^bus.addr[ADDR_W-1:DEPTH_LOG2];
        end
    endgenerate

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_DONE
    } state_t;

    state_t                state_q;
    logic [3:0]            wait_cnt_q;
    logic [DEPTH_LOG2-1:0] idx_q;
    logic                  rw_q;
    logic [DATA_W-1:0]     wdata_q;
    logic [DATA_W-1:0]     data_out_q;
    logic                  ready_q;
    logic                  busy_q;
    logic                  wp_fault_q;
    logic [DATA_W-1:0]     mem_q [DEPTH];

    logic [DEPTH_LOG2-1:0] wp_offset_d;
    logic                  protected_d;

    // Modular offset keeps the window test free of constant-zero compares.
    assign wp_offset_d = idx_q - WP_LO;
    assign protected_d = (WP_EN != 0) && (wp_offset_d <= WP_SPAN);

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            wait_cnt_q <= 4'd0;
            idx_q      <= '0;
            rw_q       <= 1'b0;
            wdata_q    <= '0;
            data_out_q <= '0;
            ready_q    <= 1'b0;
            busy_q     <= 1'b0;
            wp_fault_q <= 1'b0;
        end else begin
            ready_q    <= 1'b0;
            wp_fault_q <= 1'b0;
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (bus.req) begin
                        idx_q      <= bus.addr[DEPTH_LOG2-1:0];
                        rw_q       <= bus.rw;
                        wdata_q    <= bus.data_in;
                        wait_cnt_q <= 4'(WAIT_STATES);
                        busy_q     <= 1'b1;
                        state_q    <= ST_WAIT;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_WAIT: begin
                    // The edge that finds the counter at zero performs the access.
                    if (wait_cnt_q != 4'd0) begin
                        wait_cnt_q <= wait_cnt_q - 4'd1;
                    end else begin
                        state_q <= ST_DONE;
                        busy_q  <= 1'b0;
                        ready_q <= 1'b1;
                        if (rw_q) begin
                            data_out_q <= mem_q[idx_q];
                        end else begin
                            data_out_q <= '0;
                            if (protected_d) begin
                                wp_fault_q <= 1'b1;
                            end else begin
                                mem_q[idx_q] <= wdata_q;
                            end
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.data_out = data_out_q;
    assign bus.ready    = ready_q;
    assign bus.busy     = busy_q;
    assign bus.wp_fault = wp_fault_q;
endmodule

// File: tb/tb_bus_mem_ctrl.sv
// tb/tb_bus_mem_ctrl.sv - self-checking bench for bus_mem_ctrl (plain and wait-state/write-protect builds)
module tb_bus_mem_ctrl;
    logic clk = 1'b0;
    logic rst0;
    logic rst1;

    always #5 clk = ~clk;

    bus_mem_ctrl_if #(.ADDR_W(16), .DATA_W(8)) b0 ();
    bus_mem_ctrl_if #(.ADDR_W(16), .DATA_W(8)) b1 ();

    bus_mem_ctrl #(
        .ADDR_W(16), .DATA_W(8), .DEPTH_LOG2(11), .WAIT_STATES(0),
        .WP_EN(0), .WP_BASE(0), .WP_LIMIT(0)
    ) dut0 (
        .clock(clk), .reset(rst0), .bus(b0)
    );

    bus_mem_ctrl #(
        .ADDR_W(16), .DATA_W(8), .DEPTH_LOG2(11), .WAIT_STATES(3),
        .WP_EN(1), .WP_BASE('h100), .WP_LIMIT('h1FF)
    ) dut1 (
        .clock(clk), .reset(rst1), .bus(b1)
    );

    int   checks = 0;
    int   errors = 0;
    logic [7:0] model [2][2048];
    bit         known [2][2048];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int d, input logic r, input logic rw,
                         input logic [15:0] a, input logic [7:0] w);
        if (d == 0) begin
            b0.req = r; b0.rw = rw; b0.addr = a; b0.data_in = w;
        end else begin
            b1.req = r; b1.rw = rw; b1.addr = a; b1.data_in = w;
        end
    endtask

    task automatic sample(input int d, output logic rdy, output logic bsy,
                          output logic wpf, output logic [7:0] dout);
        if (d == 0) begin
            rdy = b0.ready; bsy = b0.busy; wpf = b0.wp_fault; dout = b0.data_out;
        end else begin
            rdy = b1.ready; bsy = b1.busy; wpf = b1.wp_fault; dout = b1.data_out;
        end
    endtask

    // One complete access; checks accept/busy and the WAIT_STATES+1 edge latency.
    task automatic access(input int d, input logic rw, input logic [15:0] a,
                          input logic [7:0] w, output logic [7:0] dout, output logic wpf);
        int lat;
        logic rdy, bsy, ww;
        logic [7:0] dd;
        @(negedge clk); drive(d, 1'b1, rw, a, w);
        @(posedge clk); #1; sample(d, rdy, bsy, ww, dd);
        check("accept_busy", 32'(bsy), 32'd1);
        @(negedge clk); drive(d, 1'b0, rw, a, w);
        lat = 0;
        rdy = 1'b0;
        while (!rdy && lat < 40) begin
            @(posedge clk); #1; lat++;
            sample(d, rdy, bsy, ww, dd);
        end
        check("latency", 32'(lat), (d == 0) ? 32'd1 : 32'd4);
        check("done_busy", 32'(bsy), 32'd0);
        dout = dd;
        wpf  = ww;
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin : main
        logic [7:0] dout, pre, wd;
        logic wpf, rdy, bsy;
        logic [7:0] got[$];
        int nrdy;
        int d;
        logic rw;
        logic [10:0] idx;
        logic [4:0] up;
        logic [15:0] a;
        bit prot;

        drive(0, 1'b0, 1'b1, 16'h0, 8'h0);
        drive(1, 1'b0, 1'b1, 16'h0, 8'h0);
        rst0 = 1'b1;
        rst1 = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            sample(k, rdy, bsy, wpf, dout);
            check("rst_ready", 32'(rdy), 32'd0);
            check("rst_busy", 32'(bsy), 32'd0);
            check("rst_wpf", 32'(wpf), 32'd0);
            check("rst_dout", 32'(dout), 32'd0);
        end
        @(negedge clk);
        rst0 = 1'b0;
        rst1 = 1'b0;

        // Basic write/read
        access(0, 1'b0, 16'h0821, 8'h31, dout, wpf);
        check("basic_wr_dout", 32'(dout), 32'h00);
        access(0, 1'b1, 16'h0821, 8'h00, dout, wpf);
        check("basic_rd_dout", 32'(dout), 32'h31);

        // Mirroring
        access(0, 1'b0, 16'h1822, 8'h14, dout, wpf);
        access(0, 1'b1, 16'h0022, 8'h00, dout, wpf);
        check("mirror_0022", 32'(dout), 32'h14);
        access(0, 1'b1, 16'h0822, 8'h00, dout, wpf);
        check("mirror_0822", 32'(dout), 32'h14);
        access(0, 1'b1, 16'h1022, 8'h00, dout, wpf);
        check("mirror_1022", 32'(dout), 32'h14);
        access(0, 1'b0, 16'h0022, 8'hAA, dout, wpf);
        access(0, 1'b1, 16'h1822, 8'h00, dout, wpf);
        check("mirror_1822", 32'(dout), 32'hAA);

        // Back-to-back reads with req held
        for (int k = 0; k < 4; k++) access(0, 1'b0, 16'(k), 8'(8'h10 + k), dout, wpf);
        @(negedge clk); drive(0, 1'b1, 1'b1, 16'h0000, 8'h00);
        for (int c = 0; c < 8; c++) begin
            @(posedge clk); #1; sample(0, rdy, bsy, wpf, dout);
            check("b2b_ready", 32'(rdy), 32'(c % 2));
            if (rdy) got.push_back(dout);
            @(negedge clk);
            if (c % 2 == 0) begin
                if (c < 6) drive(0, 1'b1, 1'b1, 16'(c / 2 + 1), 8'h00);
                else       drive(0, 1'b0, 1'b1, 16'h0000, 8'h00);
            end
        end
        check("b2b_count", 32'(got.size()), 32'd4);
        for (int k = 0; k < got.size() && k < 4; k++) check("b2b_data", 32'(got[k]), 32'(8'h10 + k));

        // Wait states: busy window, single ready, req pulses during WAIT ignored
        access(1, 1'b0, 16'h0300, 8'h3C, dout, wpf);
        @(negedge clk); drive(1, 1'b1, 1'b1, 16'h0300, 8'h00);
        @(posedge clk); #1; sample(1, rdy, bsy, wpf, dout);
        check("ws_busy_c0", 32'(bsy), 32'd1);
        nrdy = 0;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk); drive(1, (c <= 4) ? c[0] : 1'b0, 1'b1, 16'h0300, 8'h00);
            @(posedge clk); #1; sample(1, rdy, bsy, wpf, dout);
            check("ws_busy", 32'(bsy), (c <= 3) ? 32'd1 : 32'd0);
            check("ws_ready", 32'(rdy), (c == 4) ? 32'd1 : 32'd0);
            if (rdy) begin
                nrdy++;
                check("ws_data", 32'(dout), 32'h3C);
            end
        end
        check("ws_ready_count", 32'(nrdy), 32'd1);

        // Write protect: protected cell keeps its previous content
        access(1, 1'b1, 16'h0150, 8'h00, pre, wpf);
        check("wp_pre_rd_wpf", 32'(wpf), 32'd0);
        wd = ~pre;
        access(1, 1'b0, 16'h0150, wd, dout, wpf);
        check("wp_wr_fault", 32'(wpf), 32'd1);
        check("wp_wr_dout", 32'(dout), 32'h00);
        access(1, 1'b1, 16'h0150, 8'h00, dout, wpf);
        check("wp_rd_kept", 32'(dout), 32'(pre));
        check("wp_rd_wpf", 32'(wpf), 32'd0);
        access(1, 1'b0, 16'h0200, 8'h5A, dout, wpf);
        check("wp_0200_wpf", 32'(wpf), 32'd0);
        access(1, 1'b1, 16'h0200, 8'h00, dout, wpf);
        check("wp_0200_rd", 32'(dout), 32'h5A);

        // Reset during WAIT aborts the write
        access(1, 1'b0, 16'h0010, 8'h00, dout, wpf);
        @(negedge clk); drive(1, 1'b1, 1'b0, 16'h0010, 8'h77);
        @(posedge clk);
        @(negedge clk); drive(1, 1'b0, 1'b0, 16'h0010, 8'h77);
        @(posedge clk);
        @(negedge clk); rst1 = 1'b1;
        @(posedge clk); #1; sample(1, rdy, bsy, wpf, dout);
        check("mid_rst_ready", 32'(rdy), 32'd0);
        check("mid_rst_busy", 32'(bsy), 32'd0);
        check("mid_rst_dout", 32'(dout), 32'd0);
        @(negedge clk); rst1 = 1'b0;
        nrdy = 0;
        repeat (6) begin
            @(posedge clk); #1; sample(1, rdy, bsy, wpf, dout);
            if (rdy) nrdy++;
        end
        check("mid_rst_no_ready", 32'(nrdy), 32'd0);
        access(1, 1'b1, 16'h1010, 8'h00, dout, wpf);
        check("mid_rst_mem_kept", 32'(dout), 32'h00);

        // Randomized traffic against a behavioural memory model
        for (int i = 0; i < 160; i++) begin
            d   = i % 2;
            rw  = 1'($urandom_range(0, 1));
            up  = 5'($urandom);
            wd  = 8'($urandom);
            if (d == 0) idx = 11'((($urandom_range(0, 1) == 0) ? 'h000 : 'h7F0) + $urandom_range(0, 15));
            else        idx = 11'((($urandom_range(0, 1) == 0) ? 'h0F8 : 'h1F8) + $urandom_range(0, 15));
            a    = {up, idx};
            prot = (d == 1) && (idx >= 11'h100) && (idx <= 11'h1FF);
            access(d, rw, a, wd, dout, wpf);
            if (!rw) begin
                check("rnd_wr_dout", 32'(dout), 32'h00);
                check("rnd_wr_wpf", 32'(wpf), 32'(prot));
                if (!prot) begin
                    model[d][idx] = wd;
                    known[d][idx] = 1'b1;
                end
            end else begin
                check("rnd_rd_wpf", 32'(wpf), 32'd0);
                if (known[d][idx]) check("rnd_rd_data", 32'(dout), 32'(model[d][idx]));
                else begin
                    model[d][idx] = dout;
                    known[d][idx] = 1'b1;
                end
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
